spi_master_core: RTL and testbench

//  Serial engine downstream of the Avalon SPI slave. Takes the 32-bit word and go_transfer pulse

---
 rtl/spi_master_core_pkg.sv | 26 ++
 rtl/spi_master_core_if.sv | 33 +++
 rtl/spi_master_core_clk_gen.sv | 70 +++++++
 rtl/spi_master_core.sv | 139 +++++++++++++
 tb/tb_spi_master_core.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_master_core_pkg : shared state encoding and sizing helpers.   Rev 1.0
// ----------------------------------------------------------------------------
package spi_master_core_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_core_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_master_core_if : host handshake and SPI pins of the transfer engine. Rev 1.0
// ----------------------------------------------------------------------------
interface spi_master_core_if
  import spi_master_core_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              go_transfer;
  logic [DATA_W-1:0] data_write_to_spi;
  logic [DATA_W-1:0] data_read_from_spi;
  logic              data_pack_ready;
  logic              busy;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_cs_n;

  // Environment view: the Avalon slave plus whatever drives spi_miso.
  modport master (
    output go_transfer, data_write_to_spi, spi_miso,
    input  data_read_from_spi, data_pack_ready, busy, spi_sclk, spi_mosi, spi_cs_n
  );

  modport slave (
    input  go_transfer, data_write_to_spi, spi_miso,
    output data_read_from_spi, data_pack_ready, busy, spi_sclk, spi_mosi, spi_cs_n
  );

endinterface
`default_nettype wire

// File: rtl/spi_master_core_clk_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_master_core_clk_gen : sclk divider with leading/trailing edge strobes. Rev 1.0
// ----------------------------------------------------------------------------
module spi_master_core_clk_gen
  import spi_master_core_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic first_edge,
  output logic last_edge
);

  localparam int               DIV_W    = cnt_width(CLK_DIV);
  localparam int               TOG_W    = cnt_width(2 * DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             sclk_q, sclk_d;
  logic             wrap;

  always_comb begin
    wrap   = en && (div_q == DIV_LAST);
    div_d  = div_q;
    tog_d  = tog_q;
    sclk_d = sclk_q;
    if (!en) begin
      div_d  = '0;
      tog_d  = '0;
      sclk_d = CPOL;
    end else if (wrap) begin
      div_d  = '0;
      tog_d  = tog_q + 1'b1;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tog_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      div_q  <= div_d;
      tog_q  <= tog_d;
      sclk_q <= sclk_d;
    end
  end

  // Even toggle indices leave the idle level (leading), odd ones return to it.
  assign lead_edge  = wrap && !tog_q[0];
  assign trail_edge = wrap &&  tog_q[0];
  assign first_edge = wrap && (tog_q == '0);
  assign last_edge  = wrap && (tog_q == TOG_LAST);
  assign sclk       = sclk_q;

endmodule
`default_nettype wire

// File: rtl/spi_master_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_master_core : one full-duplex SPI word transfer per go_transfer edge. Rev 1.0
// ----------------------------------------------------------------------------
module spi_master_core
  import spi_master_core_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int CLK_DIV  = 4,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_master_core_if.slave bus
);

  localparam int               CNT_W      = cnt_width(max_int(CS_SETUP, CS_HOLD));
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              go_prev_q, go_prev_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic start;
  logic lead_edge, trail_edge, first_edge, last_edge;
  logic sample_edge, shift_edge;

  spi_master_core_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (state_q == ST_SHIFT),
    .sclk       (bus.spi_sclk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .first_edge (first_edge),
    .last_edge  (last_edge)
  );

  // CPHA=1 keeps the MSB on the wire through the first leading edge.
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? (lead_edge && !first_edge) : trail_edge;
  assign start       = bus.go_transfer && !go_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_prev_d = bus.go_transfer;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rd_data_d = rd_data_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_sr_d = bus.data_write_to_spi;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sample_edge) rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.spi_miso};
        if (shift_edge)  tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
        if (last_edge)   state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          rd_data_d = rx_sr_q;
          ready_d   = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      go_prev_q <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rd_data_q <= '0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      go_prev_q <= go_prev_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rd_data_q <= rd_data_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.spi_mosi           = (state_q != ST_IDLE) && tx_sr_q[DATA_W-1];
  assign bus.spi_cs_n           = cs_n_q;
  assign bus.busy               = busy_q;
  assign bus.data_pack_ready    = ready_q;
  assign bus.data_read_from_spi = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_master_core : loopback, four-mode slave and short-frame checks.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_master_core;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          start;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] tx;
    logic [31:0] exp_rx;
    int          go_len;
    bit          extra_go;
  } vec_t;
  vec_t vecs[4];

  // Default-parameter DUT with mosi looped back to miso.
  spi_master_core_if #(.DATA_W(32)) u0_if();
  assign u0_if.spi_miso = u0_if.spi_mosi;
  spi_master_core u0 (.clk(clk), .reset(reset), .bus(u0_if.slave));

  int u0_rises  = 0;
  int u0_frames = 0;
  always @(posedge u0_if.spi_sclk) if (u0_if.spi_cs_n === 1'b0) u0_rises++;
  always @(negedge u0_if.spi_cs_n) u0_frames++;

  // Short fast frame, loopback.
  spi_master_core_if #(.DATA_W(8)) u6_if();
  assign u6_if.spi_miso = u6_if.spi_mosi;
  spi_master_core #(.DATA_W(8), .CLK_DIV(1)) u6 (.clk(clk), .reset(reset), .bus(u6_if.slave));

  // One DUT per SPI mode, each talking to a behavioural slave.
  logic mode_go = 1'b0;
  generate
    for (genvar m = 0; m < 4; m++) begin : g_mode
      localparam bit MPOL = (m >= 2);
      localparam bit MPHA = ((m % 2) == 1);

      spi_master_core_if #(.DATA_W(32)) m_if();
      spi_master_core #(.CPOL(MPOL), .CPHA(MPHA)) u_m (.clk(clk), .reset(reset), .bus(m_if.slave));
      assign m_if.go_transfer       = mode_go;
      assign m_if.data_write_to_spi = 32'h0;

      logic [31:0] sl_sr        = 32'h0;
      logic        sl_cs_prev   = 1'b1;
      logic        sl_sclk_prev = MPOL;
      logic        miso_r       = 1'b0;
      assign m_if.spi_miso = miso_r;

      always @(m_if.spi_cs_n or m_if.spi_sclk) begin
        if (sl_cs_prev === 1'b1 && m_if.spi_cs_n === 1'b0) begin
          sl_sr  = 32'h1234_5678;
          miso_r = MPHA ? 1'b0 : sl_sr[31];
        end else if (m_if.spi_cs_n === 1'b0 && m_if.spi_sclk !== sl_sclk_prev) begin
          if (!MPHA && m_if.spi_sclk == MPOL) begin
            sl_sr  = sl_sr << 1;
            miso_r = sl_sr[31];
          end
          if (MPHA && m_if.spi_sclk != MPOL) begin
            miso_r = sl_sr[31];
            sl_sr  = sl_sr << 1;
          end
        end
        sl_cs_prev   = m_if.spi_cs_n;
        sl_sclk_prev = m_if.spi_sclk;
      end

      logic        done_m      = 1'b0;
      logic [31:0] rx_cap      = 32'h0;
      logic        sclk_done   = !MPOL;
      logic        sclk_cs     = !MPOL;
      logic        mon_cs_prev = 1'b1;
      always @(negedge clk) begin
        if (m_if.data_pack_ready === 1'b1 && !done_m) begin
          done_m    <= 1'b1;
          rx_cap    <= m_if.data_read_from_spi;
          sclk_done <= m_if.spi_sclk;
        end
        if (mon_cs_prev === 1'b1 && m_if.spi_cs_n === 1'b0) sclk_cs <= m_if.spi_sclk;
        mon_cs_prev <= m_if.spi_cs_n;
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_u0(input logic [31:0] tx, input logic [31:0] exp, input int go_len);
    u0_if.data_write_to_spi = tx;
    u0_if.go_transfer       = 1'b1;
    sb_q.push_back('{data: exp, start: cyc});
    for (int i = 0; i < go_len; i++) begin
      tick();
      u0_if.data_write_to_spi = ~tx;
    end
    u0_if.go_transfer = 1'b0;
  endtask

  task automatic wait_done_u0(input string tag);
    sb_t e;
    int  n = 0;
    while (u0_if.data_pack_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: completion with empty scoreboard", tag);
      return;
    end
    e = sb_q.pop_front();
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: ready not seen within %0d cycles", tag, n);
    end else begin
      check({tag, "_rx"}, u0_if.data_read_from_spi, e.data);
      check({tag, "_latency"}, cyc - e.start, 261);
    end
  endtask

  task automatic check_mode(input int m, input logic [31:0] rx, input logic sd, input logic sc,
                            input logic pol, input logic done);
    check($sformatf("mode%0d_done", m), done, 1);
    check($sformatf("mode%0d_rx", m), rx, 32'h1234_5678);
    check($sformatf("mode%0d_sclk_idle_end", m), sd, pol);
    check($sformatf("mode%0d_sclk_idle_cs", m), sc, pol);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, n, r0, f0;
    sb_t  e;

    vecs[0] = '{32'hA5C3_0F81, 32'hA5C3_0F81, 1, 1'b0};
    vecs[1] = '{32'h8000_0001, 32'h8000_0001, 7, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1, 1'b1};

    u0_if.go_transfer       = 1'b0;
    u0_if.data_write_to_spi = 32'h0;
    u6_if.go_transfer       = 1'b0;
    u6_if.data_write_to_spi = 8'h0;
    repeat (3) tick();

    check("rst_cs_n",  u0_if.spi_cs_n, 1);
    check("rst_sclk",  u0_if.spi_sclk, 0);
    check("rst_mosi",  u0_if.spi_mosi, 0);
    check("rst_busy",  u0_if.busy, 0);
    check("rst_ready", u0_if.data_pack_ready, 0);
    check("rst_rdata", u0_if.data_read_from_spi, 0);
    check("rst_sclk_cpol1", g_mode[3].m_if.spi_sclk, 1);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      r0 = u0_rises;
      f0 = u0_frames;
      start_u0(vecs[v].tx, vecs[v].exp_rx, vecs[v].go_len);
      check($sformatf("v%0d_busy", v), u0_if.busy, 1);
      if (vecs[v].extra_go) begin
        repeat (40) tick();
        u0_if.go_transfer = 1'b1;
        tick();
        tick();
        u0_if.go_transfer = 1'b0;
      end
      wait_done_u0($sformatf("v%0d", v));
      check($sformatf("v%0d_sclk_rises", v), u0_rises - r0, 32);
      repeat (3) tick();
      check($sformatf("v%0d_frames", v), u0_frames - f0, 1);
      check($sformatf("v%0d_cs_n_idle", v), u0_if.spi_cs_n, 1);
      check($sformatf("v%0d_busy_idle", v), u0_if.busy, 0);
      check($sformatf("v%0d_ready_held", v), u0_if.data_pack_ready, 1);
    end

    // Back-to-back: new go in the cycle right after ready rises.
    start_u0(32'h1357_9BDF, 32'h1357_9BDF, 1);
    wait_done_u0("b2b_a");
    start_u0(32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    check("b2b_ready_low", u0_if.data_pack_ready, 0);
    check("b2b_busy", u0_if.busy, 1);
    wait_done_u0("b2b_b");

    // A go edge in the completion cycle itself is dropped and never re-triggers.
    f0 = u0_frames;
    k  = cyc;
    start_u0(32'h5AA5_C33C, 32'h5AA5_C33C, 1);
    while (cyc < k + 260) tick();
    u0_if.go_transfer = 1'b1;
    tick();
    e = sb_q.pop_front();
    check("ign_ready", u0_if.data_pack_ready, 1);
    check("ign_rx", u0_if.data_read_from_spi, e.data);
    tick();
    tick();
    u0_if.go_transfer = 1'b0;
    repeat (3) tick();
    check("ign_busy", u0_if.busy, 0);
    check("ign_ready_held", u0_if.data_pack_ready, 1);
    check("ign_frames", u0_frames - f0, 1);

    // Reset in the middle of bit 17.
    start_u0(32'h0F0F_3C3C, 32'h0F0F_3C3C, 1);
    repeat (2 + 17 * 8) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cs_n",  u0_if.spi_cs_n, 1);
    check("mid_rst_sclk",  u0_if.spi_sclk, 0);
    check("mid_rst_ready", u0_if.data_pack_ready, 0);
    check("mid_rst_busy",  u0_if.busy, 0);
    check("mid_rst_rdata", u0_if.data_read_from_spi, 0);
    void'(sb_q.pop_back());
    tick();
    tick();
    reset = 1'b0;
    tick();
    start_u0(32'h6E5A_9182, 32'h6E5A_9182, 1);
    check("post_rst_busy", u0_if.busy, 1);
    wait_done_u0("post_rst");

    // Four SPI modes and the 8-bit CLK_DIV=1 frame, run together.
    u6_if.data_write_to_spi = 8'h81;
    u6_if.go_transfer       = 1'b1;
    mode_go                 = 1'b1;
    k = cyc;
    tick();
    u6_if.go_transfer       = 1'b0;
    u6_if.data_write_to_spi = 8'h00;
    mode_go                 = 1'b0;
    n = 0;
    while (u6_if.data_pack_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL short_timeout: ready not seen within %0d cycles", n);
    end else begin
      check("short_rx", u6_if.data_read_from_spi, 32'h81);
      check("short_latency", cyc - k, 21);
    end
    n = 0;
    while (!(g_mode[0].done_m && g_mode[1].done_m && g_mode[2].done_m && g_mode[3].done_m)
           && n < 400) begin
      tick();
      n++;
    end
    check_mode(0, g_mode[0].rx_cap, g_mode[0].sclk_done, g_mode[0].sclk_cs, 1'b0, g_mode[0].done_m);
    check_mode(1, g_mode[1].rx_cap, g_mode[1].sclk_done, g_mode[1].sclk_cs, 1'b0, g_mode[1].done_m);
    check_mode(2, g_mode[2].rx_cap, g_mode[2].sclk_done, g_mode[2].sclk_cs, 1'b1, g_mode[2].done_m);
    check_mode(3, g_mode[3].rx_cap, g_mode[3].sclk_done, g_mode[3].sclk_cs, 1'b1, g_mode[3].done_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
